fetch_stage: RTL and testbench

- Fetch stage of the pipelined ARM core; sits directly upstream of the Fetch/Decode pipeline register and produces InstrF and PCF for it.
- Owns the PC and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions in a small FIFO so Decode stalls do not drop data.
- Handles branch/PC-write redirects by flushing the buffer and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and PC step for the fetch stage.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int PC_INCR = 4;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [INSTR_W-1:0] addr_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: registered head, no bypass (push visible next cycle).
// Push and pop may coincide when full; clear and reset empty it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, in-order imem requests capped by buffer space, redirect with stale-response discard.
// FETCH_PERF_EN adds saturating perf counters (fetched, discarded, stall cycles).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH     = INSTR_W,
  parameter logic [WIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int               BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             RedirectE,
  input  logic [WIDTH-1:0] RedirectPC,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] InstrF,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] PCPlus8F,
  output logic             InstrValidF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_discarded,
  output logic [31:0]      perf_stall
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [CW-1:0]    count, outstanding, discard;
  logic [CW:0]      occupancy;
  logic [WIDTH-1:0] fpc, pcf, head;
  logic             full, empty, accept, push, pop, drop;

  // Outstanding requests reserve buffer slots so a returning response always fits.
  assign occupancy   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = !reset && !RedirectE && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_addr   = fpc;
  assign accept      = imem_req && imem_ready;
  assign drop        = imem_rvalid && (discard != '0);
  assign push        = imem_rvalid && (discard == '0) && !RedirectE;
  assign InstrValidF = !empty && !reset;
  assign pop         = InstrValidF && !StallF && !RedirectE;
  assign InstrF      = InstrValidF ? head : '0;
  assign PCF         = pcf;
  assign PCPlus8F    = pcf + WIDTH'(2 * PC_INCR);

  fetch_fifo #(.WIDTH(WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (imem_rdata),
    .pop       (pop),
    .clear     (RedirectE),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc         <= RESET_PC;
      pcf         <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (RedirectE) begin
      // Everything still in flight is stale; a response arriving now is dropped too.
      fpc         <= RedirectPC;
      pcf         <= RedirectPC;
      outstanding <= outstanding - CW'(imem_rvalid);
      discard     <= outstanding - CW'(imem_rvalid);
    end else begin
      if (accept) fpc <= fpc + WIDTH'(PC_INCR);
      if (pop)    pcf <= pcf + WIDTH'(PC_INCR);
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (drop)   discard <= discard - CW'(1);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, discarded_q, stall_q;
  logic        discard_evt;

  assign discard_evt = imem_rvalid && (RedirectE || (discard != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q   <= '0;
      discarded_q <= '0;
      stall_q     <= '0;
    end else begin
      if (pop && (fetched_q != '1))           fetched_q   <= fetched_q + 32'd1;
      if (discard_evt && (discarded_q != '1)) discarded_q <= discarded_q + 32'd1;
      if (StallF && InstrValidF && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_discarded = discarded_q;
  assign perf_stall     = stall_q;
`endif

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (outstanding != '0));
  a_redirect_aligned: assert property (@(posedge clk) disable iff (reset)
    RedirectE |-> (RedirectPC[1:0] == 2'b00));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (!full || pop));
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model plus a PC scoreboard.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RST   = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0;
  logic        RedirectE = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrF, PCF, PCPlus8F;
  logic        InstrValidF;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded, perf_stall;
`endif

  fetch_stage #(.WIDTH(32), .RESET_PC(RST), .BUF_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .RedirectE   (RedirectE),
    .RedirectPC  (RedirectPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus8F    (PCPlus8F),
    .InstrValidF (InstrValidF)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit rdy_rand = 1'b0;

  // Reference model state and queues.
  logic [31:0] m_fpc = RST;
  logic [31:0] m_pcf = RST;
  int          m_cnt = 0;
  int          m_out = 0;
  int          m_disc = 0;
  logic [31:0] exp_q[$];
  mreq_t       mq[$];

  logic        obs_req, obs_valid, obs_cons, obs_rv;
  logic [31:0] obs_addr, obs_pcf, obs_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic tick();
    logic e_req, e_valid, cons, rv, rst_s, red_s, rdy_s, dacc;
    logic [31:0] rpc_s, daddr, front;
    mreq_t r;
    #2;
    rst_s = reset; red_s = RedirectE; rpc_s = RedirectPC; rdy_s = imem_ready; rv = imem_rvalid;
    e_req   = !rst_s && !red_s && (m_cnt + m_out < DEPTH);
    e_valid = !rst_s && (m_cnt > 0);
    cons    = e_valid && !StallF && !red_s;
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = InstrValidF;
    obs_pcf = PCF; obs_instr = InstrF; obs_cons = cons; obs_rv = rv;

    n_cmp++;
    if (imem_req !== e_req) begin
      n_err++; $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, imem_req, e_req);
    end
    if (e_req) begin
      n_cmp++;
      if (imem_addr !== m_fpc) begin
        n_err++; $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, imem_addr, m_fpc);
      end
    end
    n_cmp++;
    if (InstrValidF !== e_valid) begin
      n_err++; $display("FAIL InstrValidF cyc %0d: got %b expected %b", cyc, InstrValidF, e_valid);
    end
    if (!e_valid) begin
      n_cmp++;
      if (InstrF !== 32'h0) begin
        n_err++; $display("FAIL InstrF_idle cyc %0d: got %h expected 0", cyc, InstrF);
      end
    end
    if (!rst_s) begin
      n_cmp++;
      if (PCF !== m_pcf || PCPlus8F !== m_pcf + 32'd8) begin
        n_err++; $display("FAIL PCF/PCPlus8F cyc %0d: got %h/%h expected %h/%h", cyc, PCF, PCPlus8F, m_pcf, m_pcf + 32'd8);
      end
    end
    if (cons) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL scoreboard cyc %0d: consume with empty expected queue", cyc);
      end else begin
        front = exp_q.pop_front();
        if (PCF !== front || InstrF !== instr_of(front)) begin
          n_err++; $display("FAIL consume cyc %0d: got pc %h instr %h expected pc %h instr %h", cyc, PCF, InstrF, front, instr_of(front));
        end
      end
    end
    dacc = imem_req && imem_ready; daddr = imem_addr;

    @(posedge clk);
    cyc++;
    if (rst_s) begin
      m_fpc = RST; m_pcf = RST; m_cnt = 0; m_out = 0; m_disc = 0;
      exp_q.delete(); mq.delete();
    end else begin
      if (red_s) begin
        m_fpc = rpc_s; m_pcf = rpc_s; m_out = m_out - int'(rv); m_disc = m_out; m_cnt = 0;
        exp_q.delete();
      end else begin
        if (e_req && rdy_s) begin exp_q.push_back(m_fpc); m_fpc = m_fpc + 32'd4; m_out++; end
        if (rv) begin m_out--; if (m_disc > 0) m_disc--; else m_cnt++; end
        if (cons) begin m_cnt--; m_pcf = m_pcf + 32'd4; end
      end
      if (rv && mq.size() > 0) void'(mq.pop_front());
      if (dacc) begin
        r.addr = daddr; r.due = cyc + $urandom_range(lat_min, lat_max) - 1;
        mq.push_back(r);
      end
    end
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = instr_of(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = '0;
    end
    if (rdy_rand) imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      tick();
      n_cmp++;
      if (obs_req !== 1'b0 || obs_valid !== 1'b0 || obs_instr !== 32'h0) begin
        n_err++; $display("FAIL reset_outputs: got req %b valid %b instr %h expected 0 0 0", obs_req, obs_valid, obs_instr);
      end
    end
    n_cmp++;
    if (PCF !== RST || imem_addr !== RST) begin
      n_err++; $display("FAIL reset_pc: got PCF %h addr %h expected %h", PCF, imem_addr, RST);
    end
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    int first_valid = -1;
    int ncons = 0;
    logic [31:0] last_pc = '0;
    lat_min = 1; lat_max = 1; imem_ready = 1'b1; StallF = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i < 2) begin
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== 32'(4 * i)) begin
          n_err++; $display("FAIL stream_addr%0d: got req %b addr %h expected 1 %h", i, obs_req, obs_addr, 4 * i);
        end
      end
      if (obs_valid && first_valid < 0) begin
        first_valid = i;
        n_cmp++;
        if (obs_pcf !== RST) begin
          n_err++; $display("FAIL stream_first_pc: got %h expected %h", obs_pcf, RST);
        end
      end
      if (obs_cons) begin
        if (ncons > 0) begin
          n_cmp++;
          if (obs_pcf !== last_pc + 32'd4) begin
            n_err++; $display("FAIL stream_seq: got %h expected %h", obs_pcf, last_pc + 32'd4);
          end
        end
        last_pc = obs_pcf; ncons++;
      end
    end
    n_cmp++;
    if (first_valid !== 2) begin
      n_err++; $display("FAIL stream_latency: got %0d expected 2", first_valid);
    end
    n_cmp++;
    if (ncons < 15) begin
      n_err++; $display("FAIL stream_count: got %0d expected at least 15", ncons);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int got = 0;
    RedirectE = 1'b1; RedirectPC = 32'h10; StallF = 1'b1;
    tick();
    RedirectE = 1'b0;
    while (!InstrValidF && k < 20) begin tick(); k++; end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_pcf !== 32'h10 || obs_instr !== instr_of(32'h10)) begin
        n_err++; $display("FAIL stall_hold%0d: got valid %b pc %h instr %h expected 1 00000010 %h", i, obs_valid, obs_pcf, obs_instr, instr_of(32'h10));
      end
    end
    n_cmp++;
    if (obs_req !== 1'b0) begin
      n_err++; $display("FAIL stall_full_req: got %b expected 0", obs_req);
    end
    StallF = 1'b0; k = 0;
    while (got < 3 && k < 20) begin
      tick(); k++;
      if (obs_cons) begin
        n_cmp++;
        if (obs_pcf !== 32'h10 + 32'(4 * got)) begin
          n_err++; $display("FAIL stall_release%0d: got %h expected %h", got, obs_pcf, 32'h10 + 32'(4 * got));
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 3) begin
      n_err++; $display("FAIL stall_timeout: got %0d consumed expected 3", got);
    end
  endtask

  task automatic test_redirect_stale();
    int k = 0;
    bit seen_acc = 1'b0;
    bit seen_cons = 1'b0;
    lat_min = 3; lat_max = 3;
    do_reset(2);
    while (m_out != 2 && k < 10) begin tick(); k++; end
    RedirectE = 1'b1; RedirectPC = 32'h100;
    tick();
    n_cmp++;
    if (obs_req !== 1'b0) begin
      n_err++; $display("FAIL redir_req: got %b expected 0", obs_req);
    end
    RedirectE = 1'b0; k = 0;
    while (!seen_cons && k < 20) begin
      tick(); k++;
      if (obs_req && imem_ready && !seen_acc) begin
        seen_acc = 1'b1; n_cmp++;
        if (obs_addr !== 32'h100) begin
          n_err++; $display("FAIL redir_first_addr: got %h expected 00000100", obs_addr);
        end
      end
      if (obs_cons) begin
        seen_cons = 1'b1; n_cmp++;
        if (obs_pcf !== 32'h100 || obs_instr !== instr_of(32'h100)) begin
          n_err++; $display("FAIL redir_first_instr: got pc %h instr %h expected 00000100 %h", obs_pcf, obs_instr, instr_of(32'h100));
        end
      end
    end
    n_cmp++;
    if (!seen_cons) begin
      n_err++; $display("FAIL redir_timeout: got no instruction expected one at 00000100");
    end
  endtask

  task automatic test_redirect_rvalid();
    int k = 0;
    bit seen_cons = 1'b0;
    lat_min = 2; lat_max = 2;
    do_reset(2);
    while (!(m_out == 2 && imem_rvalid) && k < 10) begin tick(); k++; end
    RedirectE = 1'b1; RedirectPC = 32'h200;
    tick();
    n_cmp++;
    if (obs_rv !== 1'b1 || obs_req !== 1'b0) begin
      n_err++; $display("FAIL redir_rv_cycle: got rvalid %b req %b expected 1 0", obs_rv, obs_req);
    end
    RedirectE = 1'b0;
    tick();
    n_cmp++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin
      n_err++; $display("FAIL redir_rv_next: got req %b addr %h expected 1 00000200", obs_req, obs_addr);
    end
    k = 0;
    while (!seen_cons && k < 20) begin
      tick(); k++;
      if (obs_cons) begin
        seen_cons = 1'b1; n_cmp++;
        if (obs_pcf !== 32'h200) begin
          n_err++; $display("FAIL redir_rv_first: got %h expected 00000200", obs_pcf);
        end
      end
    end
    n_cmp++;
    if (!seen_cons) begin
      n_err++; $display("FAIL redir_rv_timeout: got no instruction expected one at 00000200");
    end
  endtask

  task automatic test_random();
    int ncons = 0;
    int k = 0;
    bit have_last = 1'b0;
    logic [31:0] last_pc = '0;
    lat_min = 1; lat_max = 4; rdy_rand = 1'b1;
    while (ncons < 1000 && k < 20000) begin
      StallF    = ($urandom_range(0, 3) == 0);
      RedirectE = ($urandom_range(0, 99) == 0);
      RedirectPC = $urandom() & 32'hFFFF_FFFC;
      tick(); k++;
      if (RedirectE) have_last = 1'b0;
      if (obs_cons) begin
        if (have_last) begin
          n_cmp++;
          if (obs_pcf !== last_pc + 32'd4) begin
            n_err++; $display("FAIL random_seq: got %h expected %h", obs_pcf, last_pc + 32'd4);
          end
        end
        last_pc = obs_pcf; have_last = 1'b1; ncons++;
      end
    end
    StallF = 1'b0; RedirectE = 1'b0; rdy_rand = 1'b0; imem_ready = 1'b1;
    n_cmp++;
    if (ncons < 1000) begin
      n_err++; $display("FAIL random_timeout: got %0d consumed expected 1000", ncons);
    end
  endtask

  task automatic test_wrap_and_reset();
    int k = 0;
    int got = 0;
    bit seen_cons = 1'b0;
    logic [31:0] exp_pc [2];
    exp_pc[0] = 32'hFFFF_FFFC; exp_pc[1] = 32'h0;
    lat_min = 1; lat_max = 1;
    RedirectE = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    tick();
    RedirectE = 1'b0;
    while (got < 2 && k < 20) begin
      tick(); k++;
      if (obs_cons) begin
        n_cmp++;
        if (obs_pcf !== exp_pc[got]) begin
          n_err++; $display("FAIL wrap_pc%0d: got %h expected %h", got, obs_pcf, exp_pc[got]);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 2) begin
      n_err++; $display("FAIL wrap_timeout: got %0d consumed expected 2", got);
    end
    lat_min = 3; lat_max = 3; k = 0;
    while (m_out != 2 && k < 30) begin tick(); k++; end
    n_cmp++;
    if (m_out != 2) begin
      n_err++; $display("FAIL rst_mid_setup: got %0d outstanding expected 2", m_out);
    end
    do_reset(2);
    lat_min = 1; lat_max = 1;
    tick();
    n_cmp++;
    if (obs_pcf !== RST || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_pc: got pc %h valid %b expected %h 0", obs_pcf, obs_valid, RST);
    end
    k = 0;
    while (!seen_cons && k < 20) begin
      tick(); k++;
      if (obs_cons) begin
        seen_cons = 1'b1; n_cmp++;
        if (obs_pcf !== RST || obs_instr !== instr_of(RST)) begin
          n_err++; $display("FAIL rst_mid_first: got pc %h instr %h expected %h %h", obs_pcf, obs_instr, RST, instr_of(RST));
        end
      end
    end
    n_cmp++;
    if (!seen_cons) begin
      n_err++; $display("FAIL rst_mid_timeout: got no instruction expected one at %h", RST);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_stale();
    test_redirect_rvalid();
    test_random();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
